// File: rtl/canright_pkg.sv
// -----------------------------------------------------------------------------
// canright_pkg
// Shared types for the S-box datapath and the AES blocks built around it.
//   byte_t        : one GF(2^8) element / data byte
//   TAG_W_DEFAULT : default width of the requester tag
//   req_id_t      : index of a requester (0 or 1)
// -----------------------------------------------------------------------------
package canright_pkg;

    typedef logic [7:0] byte_t;

    localparam int TAG_W_DEFAULT = 2;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/canright_sbox.sv
// -----------------------------------------------------------------------------
// canright_sbox
// Purely combinational AES forward S-box: multiplicative inverse in
// GF(2^8) (modulus x^8+x^4+x^3+x+1, zero maps to zero) followed by the
// FIPS-197 affine transform.
//   data   : input byte
//   result : S-box output byte
// -----------------------------------------------------------------------------
module canright_sbox
    import canright_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] result
);

    // Shift-and-add GF(2^8) multiply, reducing by 0x1b on each overflow.
    function automatic byte_t gf_mul(byte_t a, byte_t b);
        byte_t p;
        byte_t aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic byte_t rotl(byte_t v, int n);
        return byte_t'((v << n) | (v >> (8 - n)));
    endfunction

    byte_t x2, x3, x6, x12, x14, x15;
    byte_t x30, x60, x120, x240, inv;

    // Inverse as x^254 = x^240 * x^14 via a short addition chain; x^254 of
    // zero is zero, which is exactly the S-box convention for 0x00.
    // NOTE: combinational blocks use blocking '=' so each intermediate is
    // visible to the next line in the same evaluation.
    always_comb begin
        x2     = gf_mul(data, data);
        x3     = gf_mul(x2, data);
        x6     = gf_mul(x3, x3);
        x12    = gf_mul(x6, x6);
        x15    = gf_mul(x12, x3);
        x14    = gf_mul(x12, x2);
        x30    = gf_mul(x15, x15);
        x60    = gf_mul(x30, x30);
        x120   = gf_mul(x60, x60);
        x240   = gf_mul(x120, x120);
        inv    = gf_mul(x240, x14);
        result = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                     ^ rotl(inv, 4) ^ 8'h63;
    end

endmodule

// File: rtl/sbox_arbiter.sv
// -----------------------------------------------------------------------------
// sbox_arbiter
// Two requesters share one combinational S-box. A round-robin arbiter picks
// one request per cycle; the result is captured in a one-entry response
// register together with the requester index and its tag (latency 1).
//   clk, rst_n              : clock, synchronous active-low reset
//   req0_* / req1_*         : valid/ready/data/tag request channels
//   rsp_valid / rsp_ready   : response handshake
//   rsp_data/rsp_id/rsp_tag : S-box result, served requester, echoed tag
// -----------------------------------------------------------------------------
module sbox_arbiter
    import canright_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEFAULT
)(
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [7:0]       req0_data,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [7:0]       req1_data,
    input  logic [TAG_W-1:0] req1_tag,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag
);

    req_id_t          last_grant;
    req_id_t          grant_id;
    logic             grant;
    logic             issue_ok;
    logic             accept;
    byte_t            sel_data;
    logic [TAG_W-1:0] sel_tag;
    byte_t            sbox_out;

    // Arbitration. The readys are built only from valids, response state and
    // last_grant; the data/tag mux follows the grant but never feeds back.
    always_comb begin
        issue_ok = !rsp_valid || rsp_ready;
        grant    = 1'b0;
        grant_id = REQ0;
        if (req0_valid && req1_valid) begin
            grant    = 1'b1;
            grant_id = ~last_grant;
        end else if (req0_valid) begin
            grant    = 1'b1;
            grant_id = REQ0;
        end else if (req1_valid) begin
            grant    = 1'b1;
            grant_id = REQ1;
        end

        // Gating with rst_n keeps both readys low for the whole reset cycle.
        accept     = grant && issue_ok && rst_n;
        req0_ready = accept && (grant_id == REQ0);
        req1_ready = accept && (grant_id == REQ1);

        sel_data = (grant_id == REQ1) ? req1_data : req0_data;
        sel_tag  = (grant_id == REQ1) ? req1_tag  : req0_tag;
    end

    canright_sbox u_sbox (
        .data   (sel_data),
        .result (sbox_out)
    );

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the payload registers are reset too, not just rsp_valid,
            // so a pre-reset result can never leak out as stale rsp_data.
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= REQ0;
            rsp_tag    <= '0;
            last_grant <= REQ1;
        end else if (accept) begin
            // Covers the consume-and-refill case: no bubble between results.
            rsp_valid  <= 1'b1;
            rsp_data   <= sbox_out;
            rsp_id     <= grant_id;
            rsp_tag    <= sel_tag;
            last_grant <= grant_id;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule
